// File: rtl/ram_1port_arb.sv
// ram_1port_arb: round-robin sharing of one single-port RAM between two requesters.
// Request and ack paths are purely combinational; only prio_q and the read-tag FIFO are registered.
module ram_1port_arb #(
  parameter int Width = 64,
  parameter int Size  = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  output logic                    req0_retry,
  input  logic                    req0_we,
  input  logic [$clog2(Size)-1:0] req0_pos,
  input  logic [Width-1:0]        req0_data,
  input  logic                    req1_valid,
  output logic                    req1_retry,
  input  logic                    req1_we,
  input  logic [$clog2(Size)-1:0] req1_pos,
  input  logic [Width-1:0]        req1_data,
  output logic                    ack0_valid,
  input  logic                    ack0_retry,
  output logic [Width-1:0]        ack0_data,
  output logic                    ack1_valid,
  input  logic                    ack1_retry,
  output logic [Width-1:0]        ack1_data,
  output logic                    ram_req_valid,
  output logic                    ram_req_we,
  output logic [$clog2(Size)-1:0] ram_req_pos,
  output logic [Width-1:0]        ram_req_data,
  input  logic                    ram_req_retry,
  input  logic                    ram_ack_valid,
  input  logic [Width-1:0]        ram_ack_data,
  output logic                    ram_ack_retry
);

  logic       prio_q;
  logic [1:0] tag_q;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       err_q;

  logic full, empty, head;
  logic elig0, elig1, grant0, grant1;
  logic accept, push, pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign head  = tag_q[rd_ptr_q];

  // Reads need a free tag slot; a same-cycle pop does not free one (no full-bypass).
  assign elig0  = req0_valid & (req0_we | ~full);
  assign elig1  = req1_valid & (req1_we | ~full);
  assign grant1 = elig1 & (~elig0 | prio_q);
  assign grant0 = elig0 & ~grant1;

  always_comb begin
    ram_req_valid = elig0 | elig1;
    ram_req_we    = req0_we;
    ram_req_pos   = req0_pos;
    ram_req_data  = req0_data;
    if (grant1) begin
      ram_req_we   = req1_we;
      ram_req_pos  = req1_pos;
      ram_req_data = req1_data;
    end
  end

  assign req0_retry = req0_valid & (grant0 ? ram_req_retry : 1'b1);
  assign req1_retry = req1_valid & (grant1 ? ram_req_retry : 1'b1);

  assign accept = ram_req_valid & ~ram_req_retry;
  assign push   = accept & ~ram_req_we;

  // A spurious ack (empty FIFO) is drained with retry low and goes to nobody.
  assign ack0_valid    = ram_ack_valid & ~empty & ~head;
  assign ack1_valid    = ram_ack_valid & ~empty & head;
  assign ack0_data     = ram_ack_data;
  assign ack1_data     = ram_ack_data;
  assign ram_ack_retry = ~empty & (head ? ack1_retry : ack0_retry);
  assign pop           = ram_ack_valid & ~empty & ~ram_ack_retry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q   <= 1'b0;
      tag_q    <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      if (accept) prio_q <= grant0;
      if (push) begin
        tag_q[wr_ptr_q] <= grant1;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (ram_ack_valid && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: doc/ram_1port_arb.md
# ram_1port_arb

Two-requester round-robin arbiter that shares one `ram_1port_fast` instance between two clients. It multiplexes requests onto the RAM's single valid/retry request port and tracks the owner of every outstanding read. It then steers each RAM ack back to the requester that issued the read. It adds no latency on the request or ack path; all arbitration and steering is combinational, and only the priority pointer and the tag FIFO are registered.

## Interface
- `Width`, 64, data width; must match the RAM instance.
- `Size`, 128, RAM entries; address width is `log2(Size)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `req0_valid`, `req1_valid`  in  1  requester N has a request.
- `req0_retry`, `req1_retry`  out  1  requester N is not accepted this cycle.
- `req0_we`, `req1_we`  in  1  1 = write, 0 = read.
- `req0_pos`, `req1_pos`  in  log2(Size)  address.
- `req0_data`, `req1_data`  in  Width  write data.
- `ack0_valid`, `ack1_valid`  out  1  read data for requester N.
- `ack0_retry`, `ack1_retry`  in  1  requester N stalls its ack.
- `ack0_data`, `ack1_data`  out  Width  read data.
- `ram_req_valid`, `ram_req_we`, `ram_req_pos`, `ram_req_data`  out  1/1/log2(Size)/Width  driven to the RAM request port.
- `ram_req_retry`  in  1  RAM request retry; the RAM already forces it to 0 for writes.
- `ram_ack_valid`, `ram_ack_data`  in  1/Width  RAM ack port.
- `ram_ack_retry`  out  1  backpressure to the RAM ack port.

## Operation
- **Eligibility:** requester N is eligible when `reqN_valid` is 1 and one of these holds:
  - `reqN_we` is 1, or
  - the tag FIFO is not full.
- **Read gating:** a read is blocked when the FIFO holds 2 entries, even if a pop happens in the same cycle. There is no full-bypass.
- **Grant:**
  - When only one requester is eligible, it is granted.
  - When both are eligible, the requester indicated by `prio` is granted.
  - When neither is eligible, there is no grant and `ram_req_valid` = 0.
- **RAM request:** `ram_req_*` are the granted requester's `we`/`pos`/`data`, with `ram_req_valid` = 1.
- **Requester retry:**
  - The granted requester sees `reqN_retry` = `ram_req_retry`.
  - Every other requester with `valid` = 1 sees `reqN_retry` = 1.
  - `reqN_retry` = 0 when `reqN_valid` = 0.
- **Accept:** a request is accepted when `ram_req_valid` = 1 and `ram_req_retry` = 0.
- **Priority pointer `prio`** (1 bit): on accept, `prio` ← the index of the other requester. It holds otherwise, including cycles that have a grant but no accept.
- **Tag FIFO** (2 entries, 1-bit tag holding the requester id):
  - Push: on an accepted read.
  - Pop: when `ram_ack_valid` = 1, the FIFO is not empty, and `ram_ack_retry` = 0.
  - Push and pop may occur in the same cycle.
  - Count range is 0..2; pointers wrap modulo 2.
- **Ack steering:**
  - `ackN_valid` = `ram_ack_valid` & !empty & (head == N).
  - `ackN_data` = `ram_ack_data` for both ports.
  - `ram_ack_retry` = `ack[head]_retry` when the FIFO is not empty.
- **Spurious ack** (`ram_ack_valid` = 1 with an empty FIFO): both `ackN_valid` = 0, `ram_ack_retry` = 0 so the data is drained, and sticky bit `err_q` is set. `err_q` is internal and visible to the bench by hierarchical reference.
- **Writes:** writes never touch the FIFO. A write followed by a read to the same `pos` in the next cycle returns the new data.

## Timing
- **Reset (reset = 0):** `prio` = 0, FIFO empty, `err_q` = 0.
- **Output values while in reset:**
  - `ram_req_valid` follows the inputs combinationally.
  - `ack0_valid` = `ack1_valid` = 0.
  - `ram_ack_retry` = 0.
- **Reset asserted mid-operation:** FIFO contents and `prio` are cleared immediately.
- **Request path:** zero-cycle, combinational from `reqN_*` and `ram_req_retry`.
- **Ack path:** zero-cycle, combinational from `ram_ack_*`, `ackN_retry`, and the FIFO head.
- **Read latency:** unchanged from the RAM. A read accepted in cycle T gives the earliest `ackN_valid` in cycle T+1.
- **Throughput:**
  - 1 accepted request per cycle.
  - Back-to-back reads alternate between requesters when both are continuously eligible.
- **Outstanding reads:** at most 2 in total across both requesters. While 2 are outstanding, writes continue to be granted.
- **Ordering:** acks return in RAM order. A stalled `ackN_retry` on the head blocks the other requester's acks (head-of-line blocking).

## Test plan
- **Reset:** hold reset = 0 with `req0_valid` = `req1_valid` = 1 reads -> `ram_req_valid` = 1 with requester 0 granted, `req1_retry` = 1, no FIFO push while reset = 0, `ack*_valid` = 0.
- **Round-robin:** both requesters read continuously with `ack*_retry` = 0; req0 pos 3, req1 pos 7, preloaded with 0xA and 0xB -> grants alternate 0,1,0,1; `ack0_data` = 0xA, `ack1_data` = 0xB, each one cycle after accept.
- **FIFO full:** hold `ack0_retry` = 1 and issue 2 reads from req0 -> the third read sees `req0_retry` = 1. A req1 write to pos 5 = 0x55 is still accepted. Release `ack0_retry` -> both acks arrive in order, then reads resume.
- **Read-after-write:** req0 writes pos 9 = 0x1234 in cycle T, req1 reads pos 9 in T+1 -> `ack1_data` = 0x1234.
- **RAM backpressure:** force `ram_req_retry` = 1 on reads for 3 cycles with both requesting -> `prio` is unchanged and no push occurs. On release, the requester indicated by `prio` is accepted first.
- **Spurious ack:** inject `ram_ack_valid` with an empty FIFO -> `ack0_valid` = `ack1_valid` = 0, `ram_ack_retry` = 0, `err_q` = 1 until reset.
